// File: rtl/wb_sram_if.sv
// Wishbone B3 bus bundle between one master and the wb_sram_slave responder.
// Signal names keep the slave-side _i/_o suffixes so the bundle lines up with
// the slave's documented port list.
//   wbs_cyc_i   bus cycle in progress
//   wbs_stb_i   transfer strobe
//   wbs_addr_i  word address (byte address [31:2])
//   wbs_cti_i   cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst
//   wbs_bte_i   burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   wbs_sel_i   byte enables, bit n -> data[8n+7:8n]
//   wbs_we_i    1 write, 0 read
//   wbs_data_i  write data
//   wbs_data_o  read data, valid while wbs_ack_o=1 on a read
//   wbs_ack_o   transfer acknowledge
//   wbs_err_o   address-decode error
interface wb_sram_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [29:0] wbs_addr_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic [31:0] wbs_data_i;
  logic [31:0] wbs_data_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_addr_i, wbs_cti_i, wbs_bte_i,
           wbs_sel_i, wbs_we_i, wbs_data_i,
    input  wbs_data_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_addr_i, wbs_cti_i, wbs_bte_i,
           wbs_sel_i, wbs_we_i, wbs_data_i,
    output wbs_data_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B3 slave with an on-chip synchronous RAM (2^ADDR_BITS x 32 bit).
// Serves classic cycles and incrementing bursts (linear / wrap4 / wrap8 /
// wrap16) with byte selects, optional wait states before the first ack of a
// cycle, and an error response for addresses outside its window.
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   wbs   Wishbone bundle (wb_sram_if.slave)
// Parameters:
//   ADDR_BITS    word-address width of the RAM (4..29)
//   BASE_ADDR    byte base address; decoded on address bits [31:ADDR_BITS+2]
//   WAIT_CYCLES  wait states before the first ack of each cycle (0..15)
module wb_sram_slave #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic     clk,
  input  logic     rst,
  wb_sram_if.slave wbs
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t               state;
  logic [3:0]           wait_cnt;
  logic [ADDR_BITS-1:0] ptr;
  logic [31:0]          rd_data;
  logic [31:0]          mem [2**ADDR_BITS];

  logic                 req;
  logic                 in_range;
  logic                 beat;
  logic                 burst_beat;
  logic                 wr_en;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [ADDR_BITS-1:0] ptr_next;

  // Next word of a burst: linear wraps over the whole RAM, wrapN bursts only
  // advance the low log2(N) bits and keep the block base fixed.
  function automatic logic [ADDR_BITS-1:0] next_ptr(input logic [ADDR_BITS-1:0] p,
                                                    input logic [1:0]           bte);
    logic [ADDR_BITS-1:0] inc;
    inc      = p + ADDR_BITS'(1);
    next_ptr = p;
    case (bte)
      2'b00:   next_ptr       = inc;
      2'b01:   next_ptr[1:0]  = inc[1:0];
      2'b10:   next_ptr[2:0]  = inc[2:0];
      default: next_ptr[3:0]  = inc[3:0];
    endcase
  endfunction

  assign req        = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign in_range   = (wbs.wbs_addr_i[29:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS+2]);
  assign beat       = (state == ST_DATA) & req;
  assign burst_beat = beat & (wbs.wbs_cti_i == 3'b010);
  assign wr_en      = beat & wbs.wbs_we_i;
  assign ptr_next   = next_ptr(ptr, wbs.wbs_bte_i);

  // RAM read port: the first word is fetched on the edge that accepts the
  // cycle, later burst words on the edge of the preceding beat, so the data
  // is already registered when ack rises.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rd_en   = 1'b0;
    rd_addr = ptr_next;
    if (state == ST_IDLE && req && in_range) begin
      rd_en   = 1'b1;
      rd_addr = wbs.wbs_addr_i[ADDR_BITS-1:0];
    end else if (burst_beat) begin
      rd_en   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      ptr      <= '0;
    end else if (!wbs.wbs_cyc_i) begin
      // Dropping cyc abandons the cycle wherever it is; partial bursts are legal.
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wbs.wbs_stb_i) begin
            if (!in_range) begin
              state <= ST_ERR;
            end else begin
              ptr <= wbs.wbs_addr_i[ADDR_BITS-1:0];
              if (WAIT_CYCLES == 0) begin
                state <= ST_DATA;
              end else begin
                state    <= ST_WAIT;
                wait_cnt <= WAIT_INIT;
              end
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ST_DATA;
        end
        ST_DATA: begin
          // stb low inside a cycle is a stall: ptr and read data are held.
          if (wbs.wbs_stb_i) begin
            if (wbs.wbs_cti_i == 3'b010) ptr   <= ptr_next;
            else                         state <= ST_IDLE;
          end
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wbs.wbs_sel_i[i]) mem[ptr][8*i +: 8] <= wbs.wbs_data_i[8*i +: 8];
      end
    end
  end

  assign wbs.wbs_data_o = rd_data;
  assign wbs.wbs_ack_o  = beat;
  assign wbs.wbs_err_o  = (state == ST_ERR) & req;

endmodule

// File: tb/tb_wb_sram_slave.sv
module tb_wb_sram_slave;
  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_sram_if bus();
  wb_sram_if bus2();

  // Single master driving either DUT; the unselected one sees cyc=0.
  logic        m_cyc, m_stb, m_we;
  logic [29:0] m_addr;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic [3:0]  m_sel;
  logic [31:0] m_wdata;
  logic        use_w2;
  logic        m_ack, m_err;
  logic [31:0] m_rdata;

  assign bus.wbs_cyc_i   = m_cyc & ~use_w2;
  assign bus.wbs_stb_i   = m_stb;
  assign bus.wbs_addr_i  = m_addr;
  assign bus.wbs_cti_i   = m_cti;
  assign bus.wbs_bte_i   = m_bte;
  assign bus.wbs_sel_i   = m_sel;
  assign bus.wbs_we_i    = m_we;
  assign bus.wbs_data_i  = m_wdata;
  assign bus2.wbs_cyc_i  = m_cyc & use_w2;
  assign bus2.wbs_stb_i  = m_stb;
  assign bus2.wbs_addr_i = m_addr;
  assign bus2.wbs_cti_i  = m_cti;
  assign bus2.wbs_bte_i  = m_bte;
  assign bus2.wbs_sel_i  = m_sel;
  assign bus2.wbs_we_i   = m_we;
  assign bus2.wbs_data_i = m_wdata;
  assign m_ack   = use_w2 ? bus2.wbs_ack_o  : bus.wbs_ack_o;
  assign m_err   = use_w2 ? bus2.wbs_err_o  : bus.wbs_err_o;
  assign m_rdata = use_w2 ? bus2.wbs_data_o : bus.wbs_data_o;

  wb_sram_slave #(.ADDR_BITS(AW), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .wbs(bus)
  );
  wb_sram_slave #(.ADDR_BITS(AW), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .wbs(bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: flat word array plus arithmetic burst addressing.
  logic [31:0] ref_mem [WORDS];

  function automatic int nxt(input int w, input logic [1:0] bte);
    int blk;
    blk = (bte == 2'b00) ? WORDS : (2 << bte);
    return (w - w % blk) + (w % blk + 1) % blk;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) if (sel[i]) m[8*i +: 8] = nw[8*i +: 8];
    return m;
  endfunction

  logic [31:0] beat_wdata [WORDS];
  logic [3:0]  beat_sel   [WORDS];
  logic [31:0] beat_rd    [WORDS];
  logic [31:0] exp_rd     [WORDS];
  int          beat_lat   [WORDS];
  logic        tail_ack;
  logic        xfer_ok;

  task automatic model_xfer(input int n, input int w0, input logic [1:0] bte, input logic we);
    int w;
    w = w0;
    for (int b = 0; b < n; b++) begin
      if (we) ref_mem[w] = merge(ref_mem[w], beat_wdata[b], beat_sel[b]);
      else    exp_rd[b]  = ref_mem[w];
      w = nxt(w, bte);
    end
  endtask

  // Runs one Wishbone cycle of n beats; called and returns at posedge+#1.
  task automatic xfer(input int n, input int w0, input logic [1:0] bte, input logic we,
                      input int stall_at);
    int w, k;
    w = w0;
    xfer_ok = 1'b1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_bte = bte;
    for (int b = 0; b < n; b++) begin
      m_addr  = 30'(w);
      m_cti   = (n == 1) ? 3'b000 : (b == n - 1) ? 3'b111 : 3'b010;
      m_sel   = beat_sel[b];
      m_wdata = beat_wdata[b];
      if (b == stall_at) begin
        m_stb = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          check("stall_no_ack", 32'(m_ack), 32'h0);
        end
        m_stb = 1'b1;
      end
      #1;
      k = 0;
      while (!m_ack && k < TMO) begin
        @(posedge clk); #1;
        k++;
      end
      beat_lat[b] = k;
      if (!m_ack) begin
        xfer_ok = 1'b0;
        break;
      end
      beat_rd[b] = m_rdata;
      @(posedge clk); #1;
      w = nxt(w, bte);
    end
    tail_ack = m_ack;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_cti = 3'b000;
  endtask

  typedef struct {
    logic        we;
    logic [29:0] word;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    logic [1:0] bte;
    logic we;
    int exp_words [4];

    vecs[0] = '{1'b1, 30'h004, 4'hF,    32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 30'h004, 4'hF,    32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 30'h004, 4'b0010, 32'h0000AA00, 32'h0};
    vecs[3] = '{1'b0, 30'h004, 4'h0,    32'h0,        32'hDEADAAEF};
    vecs[4] = '{1'b1, 30'h005, 4'hF,    32'h12345678, 32'h0};
    vecs[5] = '{1'b1, 30'h005, 4'b1001, 32'hAABBCCDD, 32'h0};
    vecs[6] = '{1'b0, 30'h005, 4'h3,    32'h0,        32'hAA3456DD};
    vecs[7] = '{1'b1, 30'h3FF, 4'hF,    32'h0F0F0F0F, 32'h0};
    vecs[8] = '{1'b1, 30'h3FF, 4'b0100, 32'hFFFFFFFF, 32'h0};
    vecs[9] = '{1'b0, 30'h3FF, 4'hF,    32'h0,        32'h0FFF0F0F};

    use_w2 = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_addr = '0; m_cti = '0;
    m_bte = '0; m_sel = '0; m_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 32'(m_ack), 32'h0);
    check("reset_err", 32'(m_err), 32'h0);
    check("reset_data", m_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole RAM with a linear burst so the model is fully known.
    for (int i = 0; i < WORDS; i++) begin
      beat_wdata[i] = $urandom;
      beat_sel[i]   = 4'hF;
    end
    model_xfer(WORDS, 0, 2'b00, 1'b1);
    xfer(WORDS, 0, 2'b00, 1'b1, -1);
    check("fill_ok", 32'(xfer_ok), 32'h1);

    // Table of classic transfers.
    for (int i = 0; i < 10; i++) begin
      beat_sel[0]   = vecs[i].sel;
      beat_wdata[0] = vecs[i].wdata;
      model_xfer(1, int'(vecs[i].word), 2'b00, vecs[i].we);
      xfer(1, int'(vecs[i].word), 2'b00, vecs[i].we, -1);
      check($sformatf("vec%0d_ok", i), 32'(xfer_ok), 32'h1);
      check($sformatf("vec%0d_lat", i), 32'(beat_lat[0]), 32'h1);
      check($sformatf("vec%0d_ack_one_clk", i), 32'(tail_ack), 32'h0);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), beat_rd[0], vecs[i].rexp);
    end

    // Wrap4 burst read from byte 0x38: words 0x38,0x3C,0x30,0x34.
    exp_words = '{14, 15, 12, 13};
    for (int b = 0; b < 4; b++) beat_sel[b] = 4'h0;
    xfer(4, 14, 2'b01, 1'b0, -1);
    check("wrap4_ok", 32'(xfer_ok), 32'h1);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("wrap4_data%0d", b), beat_rd[b], ref_mem[exp_words[b]]);
      check($sformatf("wrap4_lat%0d", b), 32'(beat_lat[b]), (b == 0) ? 32'h1 : 32'h0);
    end

    // Linear burst write over the top word: second beat lands at word 0.
    beat_wdata[0] = 32'hA5A50001; beat_sel[0] = 4'hF;
    beat_wdata[1] = 32'hA5A50002; beat_sel[1] = 4'hF;
    model_xfer(2, WORDS - 1, 2'b00, 1'b1);
    xfer(2, WORDS - 1, 2'b00, 1'b1, -1);
    check("topwrap_ok", 32'(xfer_ok), 32'h1);
    xfer(1, 0, 2'b00, 1'b0, -1);
    check("topwrap_word0", beat_rd[0], 32'hA5A50002);
    xfer(1, WORDS - 1, 2'b00, 1'b0, -1);
    check("topwrap_word3ff", beat_rd[0], 32'hA5A50001);

    // Out-of-range byte address 0x1000: one clk of err, no ack, no write.
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_addr = 30'h400; m_cti = 3'b000;
    m_sel = 4'hF; m_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("err_high", 32'(m_err), 32'h1);
    check("err_no_ack", 32'(m_ack), 32'h0);
    @(posedge clk); #1;
    check("err_one_clk", 32'(m_err), 32'h0);
    check("err_no_ack2", 32'(m_ack), 32'h0);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    @(posedge clk); #1;
    xfer(1, 0, 2'b00, 1'b0, -1);
    check("err_ram_unchanged", beat_rd[0], 32'hA5A50002);

    // Stall for two clocks mid-burst; the burst resumes at the held address.
    for (int b = 0; b < 4; b++) beat_sel[b] = 4'hF;
    model_xfer(4, 32, 2'b00, 1'b0);
    xfer(4, 32, 2'b00, 1'b0, 1);
    check("stall_ok", 32'(xfer_ok), 32'h1);
    for (int b = 0; b < 4; b++)
      check($sformatf("stall_data%0d", b), beat_rd[b], exp_rd[b]);
    check("stall_resume_lat", 32'(beat_lat[1]), 32'h0);

    // Reset in the middle of a burst write: only the acked beats land.
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_bte = 2'b00; m_cti = 3'b010;
    m_sel = 4'hF; m_addr = 30'h40; m_wdata = 32'h11110040;
    #1;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!m_ack && n < TMO) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("rstburst_ack%0d", b), 32'(m_ack), 32'h1);
      @(posedge clk); #1;
      m_addr  = m_addr + 30'h1;
      m_wdata = m_wdata + 32'h1;
      #1;
    end
    ref_mem[32'h40] = 32'h11110040;
    ref_mem[32'h41] = 32'h11110041;
    rst = 1'b1;
    #1;
    check("rst_ack_low", 32'(m_ack), 32'h0);
    check("rst_err_low", 32'(m_err), 32'h0);
    check("rst_data_zero", m_rdata, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_cti = 3'b000;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 32'h40 + i, 2'b00, 1'b0, -1);
      check($sformatf("rst_read%0d_ok", i), 32'(xfer_ok), 32'h1);
      check($sformatf("rst_read%0d_lat", i), 32'(beat_lat[0]), 32'h1);
      check($sformatf("rst_read%0d_data", i), beat_rd[0], ref_mem[32'h40 + i]);
    end

    // WAIT_CYCLES=2 instance: first ack 3 clk after stb, none mid-burst.
    use_w2 = 1'b1;
    beat_wdata[0] = 32'hCAFE0003; beat_wdata[1] = 32'hCAFE0004; beat_wdata[2] = 32'hCAFE0005;
    for (int b = 0; b < 3; b++) beat_sel[b] = 4'hF;
    xfer(3, 3, 2'b00, 1'b1, -1);
    check("w2_wr_ok", 32'(xfer_ok), 32'h1);
    check("w2_wr_lat0", 32'(beat_lat[0]), 32'h3);
    check("w2_wr_lat1", 32'(beat_lat[1]), 32'h0);
    check("w2_wr_lat2", 32'(beat_lat[2]), 32'h0);
    xfer(3, 3, 2'b00, 1'b0, -1);
    check("w2_rd_ok", 32'(xfer_ok), 32'h1);
    check("w2_rd_lat0", 32'(beat_lat[0]), 32'h3);
    check("w2_rd_lat2", 32'(beat_lat[2]), 32'h0);
    check("w2_rd_data0", beat_rd[0], 32'hCAFE0003);
    check("w2_rd_data1", beat_rd[1], 32'hCAFE0004);
    check("w2_rd_data2", beat_rd[2], 32'hCAFE0005);
    xfer(1, 4, 2'b00, 1'b0, -1);
    check("w2_classic_lat", 32'(beat_lat[0]), 32'h3);
    check("w2_classic_data", beat_rd[0], 32'hCAFE0004);
    check("w2_classic_tail", 32'(tail_ack), 32'h0);
    use_w2 = 1'b0;
    #1;

    // Randomized classic and burst traffic against the model.
    for (int it = 0; it < 300; it++) begin
      n   = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 8));
      w   = int'($urandom_range(0, WORDS - 1));
      bte = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      for (int b = 0; b < n; b++) begin
        beat_sel[b]   = 4'($urandom_range(0, 15));
        beat_wdata[b] = $urandom;
      end
      model_xfer(n, w, bte, we);
      xfer(n, w, bte, we, -1);
      check($sformatf("rnd%0d_ok", it), 32'(xfer_ok), 32'h1);
      check($sformatf("rnd%0d_tail", it), 32'(tail_ack), 32'h0);
      for (int b = 0; b < n; b++) begin
        check($sformatf("rnd%0d_lat%0d", it, b), 32'(beat_lat[b]), (b == 0) ? 32'h1 : 32'h0);
        if (!we) check($sformatf("rnd%0d_data%0d", it, b), beat_rd[b], exp_rd[b]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
